// File: rtl/load_extend_unit_pkg.sv
// Shared encodings and helpers for the load extend unit.
// Size codes and the supported register widths.
package load_extend_unit_pkg;

  typedef logic [1:0] size_t;

  localparam size_t SZ_BYTE  = 2'd0;
  localparam size_t SZ_HALF  = 2'd1;
  localparam size_t SZ_WORD  = 2'd2;
  localparam size_t SZ_DWORD = 2'd3;

  localparam int DW_NARROW = 32;
  localparam int DW_WIDE   = 64;

  function automatic int access_bits(size_t sz);
    return 8 << sz;
  endfunction

endpackage

// File: rtl/load_extend_unit_if.sv
// Valid/ready bundle between the MEM stage, the extender and WB.
// The master side produces beats and consumes results.
interface load_extend_unit_if
  import load_extend_unit_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int TAG_WIDTH  = 5,
  localparam int OFF_WIDTH  = $clog2(DATA_WIDTH/8)
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [OFF_WIDTH-1:0]  in_offset;
  size_t                 in_size;
  logic                  in_signed;
  logic [TAG_WIDTH-1:0]  in_tag;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_misalign;

  modport master (
    output in_valid, in_data, in_offset,
    output in_size, in_signed, in_tag,
    output out_ready,
    input  in_ready, out_valid, out_data,
    input  out_tag, out_misalign
  );

  modport slave (
    input  in_valid, in_data, in_offset,
    input  in_size, in_signed, in_tag,
    input  out_ready,
    output in_ready, out_valid, out_data,
    output out_tag, out_misalign
  );

endinterface

// File: rtl/load_extend_unit_sign_zero_ext.sv
// Widens a field to OUT_WIDTH by sign or zero fill.
// Equal widths pass through untouched.
module sign_zero_ext #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32
) (
  input  logic [IN_WIDTH-1:0]  din,
  input  logic                 sext,
  output logic [OUT_WIDTH-1:0] dout
);

  generate
    if (OUT_WIDTH > IN_WIDTH) begin : g_ext
      logic fill;
      assign fill = sext & din[IN_WIDTH-1];
      assign dout = {{(OUT_WIDTH-IN_WIDTH){fill}}, din};
    end else begin : g_pass
      logic sext_unused;
      assign sext_unused = sext;
      assign dout = din[OUT_WIDTH-1:0];
    end
  endgenerate

endmodule

// File: rtl/load_extend_unit.sv
// Load-data lane select and extension with one registered
// valid/ready output stage carrying the destination tag.
module load_extend_unit
  import load_extend_unit_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int TAG_WIDTH  = 5,
  localparam int OFF_WIDTH  = $clog2(DATA_WIDTH/8)
) (
  input logic clk,
  input logic rst_n,
  load_extend_unit_if.slave io
);

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ext_b;
  logic [DATA_WIDTH-1:0] ext_h;
  logic [DATA_WIDTH-1:0] ext_w;
  logic [DATA_WIDTH-1:0] ext_d;
  logic [DATA_WIDTH-1:0] result;
  logic [OFF_WIDTH-1:0]  amask;
  logic                  legal;
  logic                  accept;

  logic                  valid_q;
  logic                  mis_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [TAG_WIDTH-1:0]  tag_q;

  // Addressed lane is moved down to bit 0 before extension.
  assign shifted = io.in_data >> {io.in_offset, 3'b000};

  assign amask = OFF_WIDTH'(access_bits(io.in_size) / 8 - 1);
  assign legal = (access_bits(io.in_size) <= DATA_WIDTH)
              && ((io.in_offset & amask) == '0);

  sign_zero_ext #(
    .IN_WIDTH (8),
    .OUT_WIDTH(DATA_WIDTH)
  ) u_ext_b (
    .din (shifted[7:0]),
    .sext(io.in_signed),
    .dout(ext_b)
  );

  sign_zero_ext #(
    .IN_WIDTH (16),
    .OUT_WIDTH(DATA_WIDTH)
  ) u_ext_h (
    .din (shifted[15:0]),
    .sext(io.in_signed),
    .dout(ext_h)
  );

  sign_zero_ext #(
    .IN_WIDTH (32),
    .OUT_WIDTH(DATA_WIDTH)
  ) u_ext_w (
    .din (shifted[31:0]),
    .sext(io.in_signed),
    .dout(ext_w)
  );

  generate
    if (DATA_WIDTH == DW_WIDE) begin : g_dword
      sign_zero_ext #(
        .IN_WIDTH (DATA_WIDTH),
        .OUT_WIDTH(DATA_WIDTH)
      ) u_ext_d (
        .din (shifted),
        .sext(io.in_signed),
        .dout(ext_d)
      );
    end else begin : g_no_dword
      assign ext_d = '0;
    end
  endgenerate

  always_comb begin
    result = '0;
    unique case (1'b1)
      io.in_size == SZ_BYTE:  result = ext_b;
      io.in_size == SZ_HALF:  result = ext_h;
      io.in_size == SZ_WORD:  result = ext_w;
      io.in_size == SZ_DWORD: result = ext_d;
      default:                result = '0;
    endcase
    if (!legal) result = '0;
  end

  assign io.in_ready = !valid_q || io.out_ready;
  assign accept      = io.in_valid && io.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
      mis_q   <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= result;
      tag_q   <= io.in_tag;
      mis_q   <= !legal;
    end else if (io.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign io.out_valid    = valid_q;
  assign io.out_data     = data_q;
  assign io.out_tag      = tag_q;
  assign io.out_misalign = mis_q;

endmodule

// File: tb/tb_load_extend_unit.sv
// Bench for load_extend_unit: vector table, handshake
// sequences and a randomized run against a reference model.
module tb_load_extend_unit;
  import load_extend_unit_pkg::*;

  localparam int DW = 32;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_extend_unit_if #(
    .DATA_WIDTH(DW),
    .TAG_WIDTH (TW)
  ) io ();

  load_extend_unit #(
    .DATA_WIDTH(DW),
    .TAG_WIDTH (TW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  typedef struct {
    logic [31:0] d;
    logic [1:0]  off;
    logic [1:0]  sz;
    logic        sg;
    logic [4:0]  tag;
    logic [31:0] ed;
    logic        em;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  tag;
    logic        m;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[13];
  exp_t q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: pick the field arithmetically and extend it.
  function automatic void model(
    input  logic [31:0] d,
    input  logic [1:0]  off,
    input  logic [1:0]  sz,
    input  logic        sg,
    output logic [31:0] r,
    output logic        m
  );
    int w;
    longint unsigned mask, f;
    w = 8 << sz;
    m = (w > DW) || ((int'(off) % (w / 8)) != 0);
    r = '0;
    if (!m) begin
      mask = (w == 64) ? '1 : ((64'd1 << w) - 1);
      f = (64'(d) >> (8 * int'(off))) & mask;
      if (sg && f[w-1]) f = f | ~mask;
      r = f[31:0];
    end
  endfunction

  task automatic drive(input logic v, input logic [31:0] d,
                       input logic [1:0] off, input logic [1:0] sz,
                       input logic sg, input logic [4:0] tg);
    io.in_valid  = v;
    io.in_data   = d;
    io.in_offset = off;
    io.in_size   = sz;
    io.in_signed = sg;
    io.in_tag    = tg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    logic        m;
    exp_t        e;
    exp_t        thr[8];
    logic [31:0] rd;
    logic [1:0]  ro, rs;
    logic        rg;
    logic [4:0]  rt;

    tbl[0]  = '{32'h80FF_7F01, 2'd2, 2'd0, 1'b1, 5'd1,  32'hFFFF_FFFF, 1'b0};
    tbl[1]  = '{32'h80FF_7F01, 2'd2, 2'd0, 1'b0, 5'd2,  32'h0000_00FF, 1'b0};
    tbl[2]  = '{32'h80FF_7F01, 2'd2, 2'd1, 1'b1, 5'd3,  32'hFFFF_80FF, 1'b0};
    tbl[3]  = '{32'h80FF_7F01, 2'd0, 2'd2, 1'b1, 5'd4,  32'h80FF_7F01, 1'b0};
    tbl[4]  = '{32'h80FF_7F01, 2'd0, 2'd2, 1'b0, 5'd5,  32'h80FF_7F01, 1'b0};
    tbl[5]  = '{32'h80FF_7F01, 2'd1, 2'd1, 1'b1, 5'd6,  32'h0000_0000, 1'b1};
    tbl[6]  = '{32'h80FF_7F01, 2'd0, 2'd3, 1'b0, 5'd7,  32'h0000_0000, 1'b1};
    tbl[7]  = '{32'h80FF_7F01, 2'd3, 2'd0, 1'b1, 5'd8,  32'hFFFF_FF80, 1'b0};
    tbl[8]  = '{32'h80FF_7F01, 2'd1, 2'd0, 1'b1, 5'd9,  32'h0000_007F, 1'b0};
    tbl[9]  = '{32'h80FF_7F01, 2'd0, 2'd1, 1'b0, 5'd10, 32'h0000_7F01, 1'b0};
    tbl[10] = '{32'h80FF_7F01, 2'd2, 2'd2, 1'b1, 5'd11, 32'h0000_0000, 1'b1};
    tbl[11] = '{32'h80FF_7F01, 2'd2, 2'd1, 1'b0, 5'd12, 32'h0000_80FF, 1'b0};
    tbl[12] = '{32'h80FF_7F01, 2'd3, 2'd1, 1'b0, 5'd13, 32'h0000_0000, 1'b1};

    drive(1'b0, '0, '0, '0, 1'b0, '0);
    io.out_ready = 1'b0;
    #1;
    chk("rst_valid", 64'(io.out_valid), 64'd0);
    chk("rst_data", 64'(io.out_data), 64'd0);
    chk("rst_tag", 64'(io.out_tag), 64'd0);
    chk("rst_mis", 64'(io.out_misalign), 64'd0);
    chk("rst_in_ready", 64'(io.in_ready), 64'd1);
    #11 rst_n = 1'b1;
    tick();

    // Vector table at full throughput.
    io.out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, tbl[i].d, tbl[i].off, tbl[i].sz, tbl[i].sg,
            tbl[i].tag);
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(io.out_valid), 64'd1);
      chk($sformatf("vec%0d_data", i), 64'(io.out_data), 64'(tbl[i].ed));
      chk($sformatf("vec%0d_tag", i), 64'(io.out_tag), 64'(tbl[i].tag));
      chk($sformatf("vec%0d_mis", i), 64'(io.out_misalign),
          64'(tbl[i].em));
    end
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    tick();
    chk("drain_valid", 64'(io.out_valid), 64'd0);
    chk("drain_tag_hold", 64'(io.out_tag), 64'd13);
    chk("drain_mis_hold", 64'(io.out_misalign), 64'd1);

    // Back-pressure: beat A stalls, beat B waits behind it.
    io.out_ready = 1'b0;
    drive(1'b1, 32'h1234_8001, 2'd0, 2'd1, 1'b1, 5'd20);
    tick();
    chk("bp_a_valid", 64'(io.out_valid), 64'd1);
    chk("bp_a_data", 64'(io.out_data), 64'hFFFF_8001);
    drive(1'b1, 32'h5566_7788, 2'd1, 2'd0, 1'b0, 5'd21);
    #1;
    chk("bp_in_ready_low", 64'(io.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", 64'(io.out_valid), 64'd1);
      chk("bp_hold_data", 64'(io.out_data), 64'hFFFF_8001);
      chk("bp_hold_tag", 64'(io.out_tag), 64'd20);
      chk("bp_hold_ready", 64'(io.in_ready), 64'd0);
    end
    io.out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", 64'(io.in_ready), 64'd1);
    tick();
    chk("bp_b_valid", 64'(io.out_valid), 64'd1);
    chk("bp_b_data", 64'(io.out_data), 64'h0000_0077);
    chk("bp_b_tag", 64'(io.out_tag), 64'd21);
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    tick();
    chk("bp_empty", 64'(io.out_valid), 64'd0);

    // Eight back-to-back beats.
    for (int i = 0; i < 8; i++) begin
      rd = $urandom;
      rs = 2'($urandom_range(0, 2));
      ro = 2'($urandom_range(0, 3));
      rg = 1'($urandom);
      rt = 5'(i + 3);
      model(rd, ro, rs, rg, r, m);
      thr[i] = '{r, rt, m};
      drive(1'b1, rd, ro, rs, rg, rt);
      tick();
      chk($sformatf("thr%0d_valid", i), 64'(io.out_valid), 64'd1);
      chk($sformatf("thr%0d_data", i), 64'(io.out_data), 64'(thr[i].d));
      chk($sformatf("thr%0d_tag", i), 64'(io.out_tag), 64'(thr[i].tag));
      chk($sformatf("thr%0d_mis", i), 64'(io.out_misalign),
          64'(thr[i].m));
    end
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    tick();

    // Random traffic with random back-pressure.
    q.delete();
    for (int c = 0; c < 400; c++) begin
      rd = $urandom;
      rs = 2'($urandom);
      ro = 2'($urandom);
      rg = 1'($urandom);
      rt = 5'($urandom);
      drive(1'($urandom_range(0, 3) != 0), rd, ro, rs, rg, rt);
      io.out_ready = 1'($urandom_range(0, 2) != 0);
      #1;
      chk("rnd_valid", 64'(io.out_valid), 64'(q.size() != 0));
      chk("rnd_in_ready", 64'(io.in_ready),
          64'(q.size() == 0 || io.out_ready));
      if (io.out_valid && io.out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("rnd_data", 64'(io.out_data), 64'(e.d));
        chk("rnd_tag", 64'(io.out_tag), 64'(e.tag));
        chk("rnd_mis", 64'(io.out_misalign), 64'(e.m));
      end
      if (io.in_valid && (q.size() == 0)) begin
        model(rd, ro, rs, rg, r, m);
        q.push_back('{r, rt, m});
      end
      tick();
    end
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    io.out_ready = 1'b1;
    tick();

    // Asynchronous reset while stalled.
    io.out_ready = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 2'd1, 2'd1, 1'b0, 5'h1A);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    chk("ar_pre_valid", 64'(io.out_valid), 64'd1);
    chk("ar_pre_mis", 64'(io.out_misalign), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(io.out_valid), 64'd0);
    chk("ar_data", 64'(io.out_data), 64'd0);
    chk("ar_tag", 64'(io.out_tag), 64'd0);
    chk("ar_mis", 64'(io.out_misalign), 64'd0);
    #3 rst_n = 1'b1;
    tick();
    io.out_ready = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 2'd2, 2'd1, 1'b1, 5'h1B);
    tick();
    chk("ar_post_valid", 64'(io.out_valid), 64'd1);
    chk("ar_post_data", 64'(io.out_data), 64'hFFFF_DEAD);
    chk("ar_post_tag", 64'(io.out_tag), 64'h1B);
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_extend_unit.md
Name: load_extend_unit

Overview:
- Pipelined load-data extractor/extender in the MEM→WB path.
- Takes a raw memory read word, the low address bits, the access size and a signed/unsigned mode. Selects the addressed byte lane(s) and sign- or zero-extends the result to full register width.
- Generalises the fixed 16→32 zero-extender: parametrised width, sign/zero mode, byte/half/word(/dword) lane selection, alignment checking, and a registered valid/ready stage carrying the destination register tag.

Parameters:
- DATA_WIDTH, 32, memory word and register width; must be 32 or 64.
- TAG_WIDTH, 5, width of the destination register tag passed through alongside the data.
- OFF_WIDTH, $clog2(DATA_WIDTH/8), width of the byte-offset field; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept an input beat.
- in_data  in  DATA_WIDTH  raw memory read word, little-endian byte lanes.
- in_offset  in  OFF_WIDTH  address low bits; byte lane of the access.
- in_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword.
- in_signed  in  1  1 = sign-extend, 0 = zero-extend.
- in_tag  in  TAG_WIDTH  destination register tag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the output beat.
- out_data  out  DATA_WIDTH  extended load result.
- out_tag  out  TAG_WIDTH  tag registered with the beat.
- out_misalign  out  1  access was misaligned or illegal; out_data is 0.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_tag=0, out_misalign=0. Any beat in flight is dropped. The first accept is on the first rising edge after rst_n deasserts.
- Single output register stage; latency is exactly 1 cycle from input accept to out_valid.
- in_ready = !out_valid || out_ready (combinational). Full throughput of 1 beat/cycle when out_ready is held high.
- Accept occurs when in_valid && in_ready: the output register loads the new result and out_valid=1.
- Drain without refill: out_valid && out_ready && !in_valid sets out_valid=0. The data, tag and misalign registers hold their last values.
- Simultaneous drain and accept in the same cycle: the register is replaced by the new beat and out_valid stays 1.
- Stall: while out_valid && !out_ready, all output registers hold stable and in_ready=0.
- Access width W = 8<<in_size bits.
- Legality: a beat is legal iff W <= DATA_WIDTH and in_offset is a multiple of W/8.
  - W > DATA_WIDTH (e.g. size 3 when DATA_WIDTH=32) → illegal.
  - Offset not a multiple of W/8 → misaligned.
- Legal beat: field = in_data[8*in_offset +: W].
  - in_signed=1: upper bits are replicated from field[W-1].
  - in_signed=0: upper bits are 0.
  - W = DATA_WIDTH: the field passes through unchanged, regardless of in_signed.
- Illegal or misaligned beat: out_data=0, out_misalign=1. The beat still occupies the handshake and out_tag is still passed through.
- No state machine beyond the out_valid flag. The datapath is purely combinational between input and output register.

Decomposition:
- Shared package: size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_DWORD=3, and the DATA_WIDTH legality constants.
- Sub-module sign_zero_ext: combinational, parameters IN_WIDTH/OUT_WIDTH, with a mode input selecting sign or zero extension.
- Instantiate sign_zero_ext three times (8, 16, 32 bits), plus a fourth for 64 when DATA_WIDTH=64. Select the result by in_size.

Test Plan:
- Byte load: DATA_WIDTH=32, in_data=32'h80FF_7F01, offset 2, size 0. signed=1 → out_data=32'hFFFF_FFFF; signed=0 → 32'h0000_00FF. out_valid is high exactly 1 cycle after accept.
- Half/word load: offset 2, size 1, signed=1 on 32'h80FF_7F01 → 32'hFFFF_80FF. Size 2, offset 0 → 32'h80FF_7F01 unchanged.
- Misalign: size 1, offset 1 → out_data=0, out_misalign=1, tag passed through. Size 3 with DATA_WIDTH=32 → out_misalign=1.
- Back-pressure: hold out_ready=0 with 2 beats presented. First beat is held stable and in_ready=0. Raising out_ready drains beat 1 and accepts beat 2 in the same cycle, with out_valid continuously 1.
- Throughput: 8 back-to-back beats with out_ready=1 → 8 outputs on 8 consecutive cycles, in order, with tags matching.
- Reset mid-operation: assert rst_n=0 while out_valid=1 and stalled → out_valid, out_data, out_tag and out_misalign go to 0 immediately, without a clock edge. After release, a new beat is accepted normally.
